// File: rtl/seq_divider_if.sv
// Handshake and result bundle between a requester and seq_divider.
// Requester holds the master modport; the divider holds the slave modport.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   z_out;
    logic                 div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, z_out, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, z_out, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider, result {remainder, quotient} in ALU Z layout.
// Optional early exit on a zero divisor: define DIV_ZERO_DETECT_EN.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          clr,
    seq_divider_if.slave  dif
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   absb_q, absb_d;
    logic               asign_q, asign_d;
    logic               qsign_q, qsign_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] z_q, z_d;
`ifdef DIV_ZERO_DETECT_EN
    logic               dz_q, dz_d;
    logic               zdiv_q, zdiv_d;
`endif

    logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
    logic [WIDTH:0]     rem_sh;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        absb_d  = absb_q;
        asign_d = asign_q;
        qsign_d = qsign_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        z_d     = z_q;
`ifdef DIV_ZERO_DETECT_EN
        dz_d    = dz_q;
        zdiv_d  = zdiv_q;
`endif
        abs_a   = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
        abs_b   = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;
        // quo_q doubles as the dividend shift register; its MSB feeds the remainder
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        quo_fix = qsign_q ? -quo_q : quo_q;
        rem_fix = asign_q ? -rem_q : rem_q;

        case (state_q)
            S_IDLE: begin
                if (dif.start) begin
                    quo_d   = abs_a;
                    absb_d  = abs_b;
                    asign_d = dif.dividend[WIDTH-1];
                    qsign_d = dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = S_RUN;
`ifdef DIV_ZERO_DETECT_EN
                    dz_d    = 1'b0;
                    zdiv_d  = (dif.divisor == '0);
                    if (dif.divisor == '0) state_d = S_FIX;
`endif
                end
            end
            S_RUN: begin
                if (rem_sh >= {1'b0, absb_q}) begin
                    rem_d = rem_sh[WIDTH-1:0] - absb_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                z_d     = {rem_fix, quo_fix};
`ifdef DIV_ZERO_DETECT_EN
                // quo_q still holds |A| because RUN was skipped
                if (zdiv_q) begin
                    z_d  = {(asign_q ? -quo_q : quo_q), {WIDTH{1'b1}}};
                    dz_d = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            absb_q  <= '0;
            asign_q <= 1'b0;
            qsign_q <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            z_q     <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= 1'b0;
            zdiv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            absb_q  <= absb_d;
            asign_q <= asign_d;
            qsign_q <= qsign_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            z_q     <= z_d;
`ifdef DIV_ZERO_DETECT_EN
            dz_q    <= dz_d;
            zdiv_q  <= zdiv_d;
`endif
        end
    end

    assign dif.busy  = (state_q != S_IDLE);
    assign dif.done  = done_q;
    assign dif.z_out = z_q;
`ifdef DIV_ZERO_DETECT_EN
    assign dif.div_zero = dz_q;
`else
    assign dif.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; each scenario task checks its own results.
// Zero-divisor expectations follow DIV_ZERO_DETECT_EN when it is defined for the build.
module tb_seq_divider;
    logic clk;
    logic clr;
    int   tests_run;
    int   tests_failed;

    seq_divider_if #(.WIDTH(32)) dif();

    seq_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .dif (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    // Starts an operation (start sampled at the next edge, edge 0) and returns the
    // edge index of the done pulse relative to edge 0, or -1 on timeout. Leaves the
    // caller 1 time unit after the done edge. pulse_at>0 raises a stray start
    // (A=1, B=1) sampled at that edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int pulse_at,
                          output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(posedge clk); #1;
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
        if (dif.busy !== 1'b1) busy_bad++;
        for (int n = 1; n <= 40; n++) begin
            if (n == pulse_at) begin
                dif.start = 1'b1; dif.dividend = 32'd1; dif.divisor = 32'd1;
            end else begin
                dif.start = 1'b0;
            end
            @(posedge clk); #1;
            if (dif.done === 1'b1) begin
                lat = n;
                if (dif.busy !== 1'b0) busy_bad++;
                break;
            end
            if (dif.busy !== 1'b1) busy_bad++;
        end
        dif.start = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({dif.busy, dif.done, dif.div_zero} !== 3'b000 || dif.z_out !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b dz=%b z=%h, want all 0",
                     dif.busy, dif.done, dif.div_zero, dif.z_out);
        end
    endtask

    task automatic test_basic();
        int lat, bb;
        run_op(32'd100, 32'd7, 0, lat, bb);
        tests_run++;
        if (lat !== 33) begin tests_failed++; $display("FAIL basic_latency: got %0d want 33", lat); end
        tests_run++;
        if (bb !== 0) begin tests_failed++; $display("FAIL basic_busy: %0d bad busy samples, want 0", bb); end
        tests_run++;
        if (dif.z_out !== {32'h00000002, 32'h0000000E}) begin
            tests_failed++; $display("FAIL basic_z: got %h want 000000020000000e", dif.z_out);
        end
        @(posedge clk); #1;
        tests_run++;
        if (dif.done !== 1'b0 || dif.z_out !== {32'h00000002, 32'h0000000E}) begin
            tests_failed++; $display("FAIL basic_hold: done=%b z=%h want done 0, z held", dif.done, dif.z_out);
        end
    endtask

    task automatic test_signs();
        int lat, bb;
        run_op(-32'sd100, 32'd7, 0, lat, bb);
        tests_run++;
        if (lat !== 33 || dif.z_out !== {32'hFFFFFFFE, 32'hFFFFFFF2}) begin
            tests_failed++; $display("FAIL neg_dividend: lat=%0d z=%h want 33 fffffffefffffff2", lat, dif.z_out);
        end
        @(posedge clk); #1;
        run_op(32'd100, -32'sd7, 0, lat, bb);
        tests_run++;
        if (lat !== 33 || dif.z_out !== {32'h00000002, 32'hFFFFFFF2}) begin
            tests_failed++; $display("FAIL neg_divisor: lat=%0d z=%h want 33 00000002fffffff2", lat, dif.z_out);
        end
        @(posedge clk); #1;
        run_op(-32'sd100, -32'sd7, 0, lat, bb);
        tests_run++;
        if (dif.z_out !== {32'hFFFFFFFE, 32'h0000000E}) begin
            tests_failed++; $display("FAIL both_neg: z=%h want fffffffe0000000e", dif.z_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat, bb;
        run_op(32'h80000000, 32'hFFFFFFFF, 0, lat, bb);
        tests_run++;
        if (lat !== 33 || dif.z_out !== {32'h00000000, 32'h80000000} || dif.div_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL min_by_minus1: lat=%0d z=%h dz=%b want 33 0000000080000000 0", lat, dif.z_out, dif.div_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_div();
        int lat, bb;
        run_op(32'd55, 32'd0, 0, lat, bb);
        tests_run++;
        if (lat !== (DZ_EN ? 1 : 33)) begin
            tests_failed++; $display("FAIL zero_latency: got %0d want %0d", lat, DZ_EN ? 1 : 33);
        end
        tests_run++;
        if (dif.z_out !== {32'h00000037, 32'hFFFFFFFF} || dif.div_zero !== DZ_EN) begin
            tests_failed++; $display("FAIL zero_pos: z=%h dz=%b want 00000037ffffffff %b", dif.z_out, dif.div_zero, DZ_EN);
        end
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (dif.div_zero !== DZ_EN) begin
            tests_failed++; $display("FAIL zero_sticky: dz=%b want %b", dif.div_zero, DZ_EN);
        end
        run_op(-32'sd55, 32'd0, 0, lat, bb);
        tests_run++;
        if (dif.z_out !== {32'hFFFFFFC9, (DZ_EN ? 32'hFFFFFFFF : 32'h00000001)}) begin
            tests_failed++; $display("FAIL zero_neg: z=%h want ffffffc9%h", dif.z_out, DZ_EN ? 32'hFFFFFFFF : 32'h00000001);
        end
        @(posedge clk); #1;
        run_op(32'd100, 32'd7, 0, lat, bb);
        tests_run++;
        if (dif.div_zero !== 1'b0 || dif.z_out !== {32'h00000002, 32'h0000000E}) begin
            tests_failed++; $display("FAIL zero_cleared: dz=%b z=%h want 0 000000020000000e", dif.div_zero, dif.z_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat, bb;
        run_op(32'd9, 32'd2, 10, lat, bb);
        tests_run++;
        if (lat !== 33 || bb !== 0 || dif.z_out !== {32'd1, 32'd4}) begin
            tests_failed++; $display("FAIL ignore_start: lat=%0d busybad=%0d z=%h want 33 0 0000000100000004", lat, bb, dif.z_out);
        end
        // start raised inside the done cycle, sampled at edge 34
        run_op(32'd8, 32'd3, 0, lat, bb);
        tests_run++;
        if (lat !== 33 || dif.z_out !== {32'd2, 32'd2}) begin
            tests_failed++; $display("FAIL done_cycle_start: lat=%0d z=%h want 33 0000000200000002", lat, dif.z_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr_mid();
        int lat, bb, dones;
        dif.start = 1'b1; dif.dividend = 32'd100; dif.divisor = 32'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        tests_run++;
        if ({dif.busy, dif.done} !== 2'b00 || dif.z_out !== 64'd0) begin
            tests_failed++; $display("FAIL clr_async: busy=%b done=%b z=%h want 0 0 0", dif.busy, dif.done, dif.z_out);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL clr_no_done: %0d done pulses, want 0", dones); end
        run_op(32'd100, 32'd7, 0, lat, bb);
        tests_run++;
        if (lat !== 33 || bb !== 0 || dif.z_out !== {32'h00000002, 32'h0000000E}) begin
            tests_failed++; $display("FAIL clr_restart: lat=%0d busybad=%0d z=%h want 33 0 000000020000000e", lat, bb, dif.z_out);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        clr = 1'b1;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        clr = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_signs();
        test_overflow();
        test_zero_div();
        test_back_to_back();
        test_clr_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle signed divider; produces the 64-bit {HI, LO} result that the ALU drives onto Z for the divide opcode.
- HI = remainder, LO = quotient.
- Replaces the single-cycle % and / path with a 32-iteration restoring divider behind a start/busy/done handshake.
- Result word is laid out exactly as the ALU's 64-bit Z output.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH; iteration counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- dividend  in  WIDTH  signed A; captured on the accepting edge.
- divisor  in  WIDTH  signed B; captured on the accepting edge.
- busy  out  1  operation in progress.
- done  out  1  one-cycle result-valid pulse.
- z_out  out  2*WIDTH  {remainder, quotient}; registered.
- div_zero  out  1  divisor was zero (see Optional Feature).

Behaviour:
- Reset (clr=1, any time, including mid-operation):
  - busy=0, done=0, z_out=0, div_zero=0.
  - State returns to IDLE; internal remainder, quotient and counter cleared.
  - Operation in flight is discarded, with no done pulse.
- States: IDLE, RUN, FIX.
- IDLE: on start=1 at edge 0:
  - capture |A|, |B|, sign(A), sign(A) xor sign(B);
  - clear the partial remainder; counter=WIDTH; busy=1; go to RUN.
- RUN, one iteration per edge (edges 1..32):
  - shift {rem, quo} left 1, feeding in the next dividend bit;
  - if rem >= |B|: rem -= |B|, quotient bit=1; else quotient bit=0;
  - decrement the counter; when it reaches 0, go to FIX.
- FIX (edge 33):
  - quotient negated if the signs differ; remainder negated if A<0;
  - z_out loaded; done=1 and busy=0 for the cycle between edges 33 and 34; return to IDLE.
- Arithmetic:
  - truncation toward zero; the remainder takes the sign of the dividend;
  - |x| is computed as an unsigned WIDTH-bit value, so -2^31 maps to 0x80000000;
  - -2^31 / -1 gives quotient 0x80000000 and remainder 0 (wraps, no flag).
- z_out holds its value until the next FIX; it is not cleared by start.
- start while busy=1 is ignored, with no queuing.
- start asserted in the done cycle is accepted (busy=0 then); done and the new busy coincide for that cycle.
- Back-to-back throughput: one result per 34 cycles.
- Inputs are not required to be held stable after the accepting edge.

Optional Feature:
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - divisor==0 at the accepting edge skips RUN;
  - at edge 1: z_out = {A, 0xFFFFFFFF}, div_zero=1, done=1, busy=0;
  - div_zero stays high until the next accepted start or clr.
- Undefined:
  - div_zero is tied 0 and there is no early exit;
  - a zero divisor runs the full 34 cycles and yields the natural algorithm result: remainder = A;
  - quotient = 0xFFFFFFFF when A>=0, 0x00000001 when A<0.

Test Plan:
1. start with A=100, B=7 at edge 0 -> done at edge 33 only; z_out = {0x00000002, 0x0000000E}; busy high for edges 0..32.
2. A=-100, B=7 -> z_out = {0xFFFFFFFE, 0xFFFFFFF2}; then A=100, B=-7 -> z_out = {0x00000002, 0xFFFFFFF2}.
3. A=0x80000000, B=0xFFFFFFFF -> z_out = {0x00000000, 0x80000000}, div_zero=0.
4. A=55, B=0:
   - with DIV_ZERO_DETECT_EN -> done at edge 1, z_out = {0x00000037, 0xFFFFFFFF}, div_zero=1;
   - without it -> done at edge 33, same z_out, div_zero=0.
5. start A=9, B=2, then pulse start with A=1, B=1 at edge 10 -> ignored; z_out = {1, 4} at edge 33. A new start in the done cycle with A=8, B=3 -> accepted; z_out = {2, 2} at edge 67.
6. Pulse clr asynchronously at mid-edge 15 of a 100/7 run -> busy, done and z_out go to 0 immediately, with no done pulse. A fresh start afterwards gives the correct result after 34 cycles.
